mc_ctrl: RTL and testbench

Multi-cycle main controller for the MIPS-lite datapath. It drives the 4-bit one-hot ALU operation code and every other datapath control.
- Decodes Op/Funct from the instruction register and steps a Moore FSM through fetch/decode/execute/memory/writeback.
- Consumes the ALU Zero flag to resolve beq.
- Counts retired instructions for the testbench.

---
 rtl/mc_ctrl.sv | 191 +++++++++++++++++++
 tb/tb_mc_ctrl.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/mc_ctrl.sv
// Multi-cycle Moore controller for the MIPS-lite datapath: fetch/decode/execute/
// memory/writeback sequencing, datapath control decode and a retired-instruction counter.
module mc_ctrl #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [5:0]       Op,
  input  logic [5:0]       Funct,
  input  logic             Zero,
  output logic             PCWrite,
  output logic             IRWrite,
  output logic             RegWrite,
  output logic             MemWrite,
  output logic             ALUSrcA,
  output logic [1:0]       ALUSrcB,
  output logic [3:0]       ALUCtrl,
  output logic [1:0]       ExtOp,
  output logic             RegDst,
  output logic             MemtoReg,
  output logic [1:0]       PCSrc,
  output logic [3:0]       State,
  output logic [CNT_W-1:0] InstrCnt
);

  localparam logic [3:0] S_FETCH  = 4'd0;
  localparam logic [3:0] S_DECODE = 4'd1;
  localparam logic [3:0] S_MEMADR = 4'd2;
  localparam logic [3:0] S_MEMRD  = 4'd3;
  localparam logic [3:0] S_MEMWB  = 4'd4;
  localparam logic [3:0] S_MEMWR  = 4'd5;
  localparam logic [3:0] S_REXE   = 4'd6;
  localparam logic [3:0] S_IEXE   = 4'd7;
  localparam logic [3:0] S_ALUWB  = 4'd8;
  localparam logic [3:0] S_BRANCH = 4'd9;
  localparam logic [3:0] S_JUMP   = 4'd10;

  localparam logic [3:0] C_NONE = 4'd0;
  localparam logic [3:0] C_ADDU = 4'd1;
  localparam logic [3:0] C_SUBU = 4'd2;
  localparam logic [3:0] C_ORI  = 4'd3;
  localparam logic [3:0] C_LUI  = 4'd4;
  localparam logic [3:0] C_LW   = 4'd5;
  localparam logic [3:0] C_SW   = 4'd6;
  localparam logic [3:0] C_BEQ  = 4'd7;
  localparam logic [3:0] C_J    = 4'd8;

  logic [3:0]       state;
  logic [3:0]       state_nxt;
  logic [3:0]       cls;
  logic [3:0]       cls_dec;
  logic [CNT_W-1:0] cnt;
  logic             retire;
  logic             pc_write;
  logic             ir_write;
  logic             reg_write;
  logic             mem_write;

  always_comb begin
    cls_dec = C_NONE;
    case (Op)
      6'b000000: begin
        if (Funct == 6'b100001)      cls_dec = C_ADDU;
        else if (Funct == 6'b100011) cls_dec = C_SUBU;
      end
      6'b001101: cls_dec = C_ORI;
      6'b001111: cls_dec = C_LUI;
      6'b100011: cls_dec = C_LW;
      6'b101011: cls_dec = C_SW;
      6'b000100: cls_dec = C_BEQ;
      6'b000010: cls_dec = C_J;
      default:   cls_dec = C_NONE;
    endcase
  end

  // Only DECODE looks at live Op/Funct; every later state steers on the latched class.
  always_comb begin
    state_nxt = S_FETCH;
    case (state)
      S_FETCH: state_nxt = S_DECODE;
      S_DECODE: begin
        case (cls_dec)
          C_LW, C_SW:     state_nxt = S_MEMADR;
          C_ADDU, C_SUBU: state_nxt = S_REXE;
          C_ORI, C_LUI:   state_nxt = S_IEXE;
          C_BEQ:          state_nxt = S_BRANCH;
          C_J:            state_nxt = S_JUMP;
          default:        state_nxt = S_FETCH;
        endcase
      end
      S_MEMADR: state_nxt = (cls == C_SW) ? S_MEMWR : S_MEMRD;
      S_MEMRD:  state_nxt = S_MEMWB;
      S_REXE:   state_nxt = S_ALUWB;
      S_IEXE:   state_nxt = S_ALUWB;
      default:  state_nxt = S_FETCH;
    endcase
  end

  always_comb begin
    pc_write  = 1'b0;
    ir_write  = 1'b0;
    reg_write = 1'b0;
    mem_write = 1'b0;
    ALUSrcA   = 1'b0;
    ALUSrcB   = 2'b00;
    ALUCtrl   = 4'b0000;
    ExtOp     = 2'b00;
    RegDst    = 1'b0;
    MemtoReg  = 1'b0;
    PCSrc     = 2'b00;
    case (state)
      S_FETCH: begin
        ir_write = 1'b1;
        pc_write = 1'b1;
        ALUSrcB  = 2'b01;
        ALUCtrl  = 4'b0001;
      end
      S_DECODE: begin
        ALUSrcB = 2'b11;
        ExtOp   = 2'b01;
        ALUCtrl = 4'b0001;
      end
      S_MEMADR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        ExtOp   = 2'b01;
        ALUCtrl = 4'b0001;
      end
      S_MEMWB: begin
        reg_write = 1'b1;
        MemtoReg  = 1'b1;
      end
      S_MEMWR: mem_write = 1'b1;
      S_REXE: begin
        ALUSrcA = 1'b1;
        ALUCtrl = (cls == C_SUBU) ? 4'b0010 : 4'b0001;
      end
      S_IEXE: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        if (cls == C_LUI) begin
          ExtOp   = 2'b10;
          ALUCtrl = 4'b1000;
        end else begin
          ExtOp   = 2'b00;
          ALUCtrl = 4'b0100;
        end
      end
      S_ALUWB: begin
        reg_write = 1'b1;
        RegDst    = (cls == C_ADDU) || (cls == C_SUBU);
      end
      S_BRANCH: begin
        ALUSrcA  = 1'b1;
        ALUCtrl  = 4'b0010;
        PCSrc    = 2'b01;
        pc_write = Zero;
      end
      S_JUMP: begin
        pc_write = 1'b1;
        PCSrc    = 2'b10;
      end
      default: ;
    endcase
  end

  // Write enables are suppressed combinationally so nothing commits while reset is held.
  assign PCWrite  = pc_write  & ~reset;
  assign IRWrite  = ir_write  & ~reset;
  assign RegWrite = reg_write & ~reset;
  assign MemWrite = mem_write & ~reset;

  assign retire = (state == S_MEMWB) || (state == S_MEMWR) || (state == S_ALUWB) ||
                  (state == S_BRANCH) || (state == S_JUMP);

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_FETCH;
      cls   <= C_NONE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      if (state == S_DECODE) cls <= cls_dec;
      if (retire) cnt <= cnt + CNT_W'(1);
    end
  end

  assign State    = state;
  assign InstrCnt = cnt;

endmodule

// File: tb/tb_mc_ctrl.sv
// Bench for mc_ctrl: directed scenarios plus random instruction streams, each cycle's
// controls checked against an instruction-level reference model.
module tb_mc_ctrl;

  logic        clk;
  logic        reset;
  logic [5:0]  Op;
  logic [5:0]  Funct;
  logic        Zero;
  logic        PCWrite, IRWrite, RegWrite, MemWrite, ALUSrcA, RegDst, MemtoReg;
  logic [1:0]  ALUSrcB, ExtOp, PCSrc;
  logic [3:0]  ALUCtrl, State;
  logic [31:0] InstrCnt;
  logic        PCWrite4, IRWrite4, RegWrite4, MemWrite4, ALUSrcA4, RegDst4, MemtoReg4;
  logic [1:0]  ALUSrcB4, ExtOp4, PCSrc4;
  logic [3:0]  ALUCtrl4, State4;
  logic [3:0]  InstrCnt4;

  int checks = 0;
  int failures = 0;
  int exp_cnt = 0;
  logic [20:0] exp_q[$];

  localparam int K_ADDU = 0, K_SUBU = 1, K_ORI = 2, K_LUI = 3, K_LW = 4,
                 K_SW = 5, K_BEQ = 6, K_J = 7, K_ILL = 8;

  mc_ctrl #(.CNT_W(32)) dut (
    .clk(clk), .reset(reset), .Op(Op), .Funct(Funct), .Zero(Zero),
    .PCWrite(PCWrite), .IRWrite(IRWrite), .RegWrite(RegWrite), .MemWrite(MemWrite),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUCtrl(ALUCtrl), .ExtOp(ExtOp),
    .RegDst(RegDst), .MemtoReg(MemtoReg), .PCSrc(PCSrc), .State(State),
    .InstrCnt(InstrCnt)
  );

  mc_ctrl #(.CNT_W(4)) dut4 (
    .clk(clk), .reset(reset), .Op(Op), .Funct(Funct), .Zero(Zero),
    .PCWrite(PCWrite4), .IRWrite(IRWrite4), .RegWrite(RegWrite4), .MemWrite(MemWrite4),
    .ALUSrcA(ALUSrcA4), .ALUSrcB(ALUSrcB4), .ALUCtrl(ALUCtrl4), .ExtOp(ExtOp4),
    .RegDst(RegDst4), .MemtoReg(MemtoReg4), .PCSrc(PCSrc4), .State(State4),
    .InstrCnt(InstrCnt4)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int classify(input logic [5:0] op, input logic [5:0] fn);
    case (op)
      6'b000000: return (fn == 6'b100001) ? K_ADDU : (fn == 6'b100011) ? K_SUBU : K_ILL;
      6'b001101: return K_ORI;
      6'b001111: return K_LUI;
      6'b100011: return K_LW;
      6'b101011: return K_SW;
      6'b000100: return K_BEQ;
      6'b000010: return K_J;
      default:   return K_ILL;
    endcase
  endfunction

  // Reference model: the state walk of each instruction class.
  function automatic int plen(input int k);
    case (k)
      K_LW:                      return 5;
      K_ADDU, K_SUBU, K_ORI, K_LUI, K_SW: return 4;
      K_BEQ, K_J:                return 3;
      default:                   return 2;
    endcase
  endfunction

  function automatic logic [3:0] pstate(input int k, input int i);
    logic [3:0] p [5];
    case (k)
      K_ADDU, K_SUBU: p = '{4'd0, 4'd1, 4'd6, 4'd8, 4'd0};
      K_ORI, K_LUI:   p = '{4'd0, 4'd1, 4'd7, 4'd8, 4'd0};
      K_LW:           p = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4};
      K_SW:           p = '{4'd0, 4'd1, 4'd2, 4'd5, 4'd0};
      K_BEQ:          p = '{4'd0, 4'd1, 4'd9, 4'd0, 4'd0};
      K_J:            p = '{4'd0, 4'd1, 4'd10, 4'd0, 4'd0};
      default:        p = '{4'd0, 4'd1, 4'd0, 4'd0, 4'd0};
    endcase
    return p[i];
  endfunction

  // Expected control word {PCWrite,IRWrite,RegWrite,MemWrite,ALUSrcA,ALUSrcB,ALUCtrl,ExtOp,RegDst,MemtoReg,PCSrc,State}
  function automatic logic [20:0] exp_ctrl(input int k, input logic [3:0] s, input logic z,
                                           input logic rst);
    logic pcw, irw, rw, mw, sa, rd, m2r;
    logic [1:0] sb, ext, pcs;
    logic [3:0] alu;
    {pcw, irw, rw, mw, sa, rd, m2r} = '0;
    sb = 2'b00; ext = 2'b00; pcs = 2'b00; alu = 4'b0000;
    case (s)
      4'd0:  begin irw = 1; pcw = 1; sb = 2'b01; alu = 4'b0001; end
      4'd1:  begin sb = 2'b11; ext = 2'b01; alu = 4'b0001; end
      4'd2:  begin sa = 1; sb = 2'b10; ext = 2'b01; alu = 4'b0001; end
      4'd4:  begin rw = 1; m2r = 1; end
      4'd5:  mw = 1;
      4'd6:  begin sa = 1; alu = (k == K_SUBU) ? 4'b0010 : 4'b0001; end
      4'd7:  begin sa = 1; sb = 2'b10; ext = (k == K_ORI) ? 2'b00 : 2'b10;
                   alu = (k == K_ORI) ? 4'b0100 : 4'b1000; end
      4'd8:  begin rw = 1; rd = (k == K_ADDU) || (k == K_SUBU); end
      4'd9:  begin sa = 1; alu = 4'b0010; pcs = 2'b01; pcw = z; end
      4'd10: begin pcw = 1; pcs = 2'b10; end
      default: ;
    endcase
    if (rst) {pcw, irw, rw, mw} = '0;
    return {pcw, irw, rw, mw, sa, sb, alu, ext, rd, m2r, pcs, s};
  endfunction

  function automatic logic [20:0] obs_ctrl();
    return {PCWrite, IRWrite, RegWrite, MemWrite, ALUSrcA, ALUSrcB, ALUCtrl, ExtOp,
            RegDst, MemtoReg, PCSrc, State};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_cnt(input string tag);
    check({tag, "_cnt32"}, InstrCnt, 32'(exp_cnt));
    check({tag, "_cnt4"}, {28'd0, InstrCnt4}, {28'd0, 4'(exp_cnt)});
  endtask

  // Driver: entered at a falling edge with the DUT in FETCH. zmode 0/1 fixes Zero, 2 randomises it.
  // abort_at >= 0 asserts reset in that cycle of the walk instead of completing the instruction.
  task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input int zmode,
                           input int abort_at, input string tag);
    int k, n;
    logic [3:0] s;
    logic z [5];
    logic [20:0] e;
    k = classify(op, fn);
    n = plen(k);
    for (int i = 0; i < n; i++) begin
      z[i] = (zmode == 2) ? 1'($urandom_range(0, 1)) : 1'(zmode);
      exp_q.push_back(exp_ctrl(k, pstate(k, i), z[i], (i == abort_at)));
    end
    Op = op;
    Funct = fn;
    for (int i = 0; i < n; i++) begin
      Zero = z[i];
      if (i == abort_at) reset = 1'b1;
      #1;
      e = exp_q.pop_front();
      check($sformatf("%s_c%0d", tag, i), {11'd0, obs_ctrl()}, {11'd0, e});
      @(posedge clk);
      @(negedge clk);
      if (i == abort_at) break;
    end
    if (abort_at >= 0) begin
      exp_cnt = 0;
      s = 4'd0;
      check({tag, "_abort_state"}, {28'd0, State}, {28'd0, s});
      reset = 1'b0;
      exp_q.delete();
    end else if (k != K_ILL) begin
      exp_cnt++;
    end
    check_cnt(tag);
  endtask

  initial begin
    int r;
    logic [5:0] rop, rfn;
    reset = 1'b1;
    Op = 6'b000000;
    Funct = 6'b100001;
    Zero = 1'b0;
    for (int c = 0; c < 2; c++) begin
      @(posedge clk);
      @(negedge clk);
      check($sformatf("reset_c%0d", c), {11'd0, obs_ctrl()}, {11'd0, exp_ctrl(K_ILL, 4'd0, 1'b0, 1'b1)});
      check_cnt("reset");
    end
    reset = 1'b0;

    run_instr(6'b000000, 6'b100001, 0, -1, "addu");
    run_instr(6'b100011, 6'h15, 2, -1, "lw");
    run_instr(6'b101011, 6'h2a, 2, -1, "sw");
    run_instr(6'b000100, 6'h00, 1, -1, "beq_taken");
    run_instr(6'b000100, 6'h00, 0, -1, "beq_not");
    run_instr(6'b001101, 6'h3f, 2, -1, "ori");
    run_instr(6'b001111, 6'h01, 2, -1, "lui");
    run_instr(6'b000000, 6'b100011, 2, -1, "subu");
    run_instr(6'b111111, 6'h21, 2, -1, "illegal_op");
    run_instr(6'b000000, 6'b000000, 2, -1, "illegal_fn");
    run_instr(6'b100011, 6'h00, 2, 3, "lw_reset_memrd");
    run_instr(6'b000000, 6'b100001, 2, 3, "addu_reset_aluwb");

    for (int i = 0; i < 16; i++) run_instr(6'b000010, 6'h00, 2, -1, "j_wrap");
    check("wrap4", {28'd0, InstrCnt4}, 32'd0);
    check("wrap32", InstrCnt, 32'd16);

    for (int i = 0; i < 80; i++) begin
      r = $urandom_range(0, 9);
      rfn = 6'($urandom);
      case (r)
        0: begin rop = 6'b000000; rfn = 6'b100001; end
        1: begin rop = 6'b000000; rfn = 6'b100011; end
        2: rop = 6'b001101;
        3: rop = 6'b001111;
        4: rop = 6'b100011;
        5: rop = 6'b101011;
        6: rop = 6'b000100;
        7: rop = 6'b000010;
        8: rop = 6'($urandom);
        default: rop = 6'b000000;
      endcase
      run_instr(rop, rfn, 2, -1, $sformatf("rand%0d", i));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
